hk_rr_mux: RTL and testbench

- Parametrised, single-clock, multi-channel valid/ready handshake concentrator.
- NCH independent write channels, each buffered in its own DEPTH-entry FIFO, are merged onto one read channel by a fair round-robin arbiter.
- Sits downstream of the point-to-point handshake blocks wherever several producers share one consumer.
- Adds data payload, per-channel buffering, arbitration and source tagging, which the single-bit handshake does not have.

---
 rtl/hk_pkg.sv | 33 +++
 rtl/hk_fifo.sv | 53 +++++
 rtl/hk_rr_mux.sv | 105 ++++++++++
 tb/tb_hk_rr_mux.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hk_pkg.sv
// Shared constants and the round-robin search helper for hk_rr_mux.
package hk_pkg;

  localparam int unsigned HK_NCH     = 4;
  localparam int unsigned HK_DATA_W  = 8;
  localparam int unsigned HK_DEPTH   = 2;
  // Widest channel count the request vector and grant index can carry.
  localparam int unsigned HK_MAX_NCH = 16;

  typedef struct packed {
    logic       vld;
    logic [3:0] idx;
  } rr_grant_t;

  // First set bit of req found by scanning ptr, ptr+1, ... modulo nch.
  function automatic rr_grant_t rr_next(input logic [HK_MAX_NCH-1:0] req,
                                        input logic [3:0]            ptr,
                                        input int unsigned           nch);
    rr_grant_t   g;
    int unsigned c;
    g = '0;
    for (int unsigned k = 0; k < HK_MAX_NCH; k++) begin
      c = 32'(ptr) + k;
      if (c >= nch) c = c - nch;
      if (k < nch && !g.vld && req[c[3:0]]) begin
        g.vld = 1'b1;
        g.idx = c[3:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/hk_fifo.sv
// Per-channel FIFO with wrap-bit pointers; push/pop are ignored when full/empty.
module hk_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage; push and pop may both happen in one cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer state resets to empty; storage contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/hk_rr_mux.sv
// NCH buffered write channels merged onto one registered read channel by round-robin.
module hk_rr_mux
  import hk_pkg::*;
#(
  parameter int unsigned NCH    = HK_NCH,
  parameter int unsigned DATA_W = HK_DATA_W,
  parameter int unsigned DEPTH  = HK_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          wr_vld,
  output logic [NCH-1:0]          wr_rdy,
  input  logic [NCH*DATA_W-1:0]   wr_data,
  output logic                    rd_vld,
  input  logic                    rd_rdy,
  output logic [DATA_W-1:0]       rd_data,
  output logic [$clog2(NCH)-1:0]  rd_ch
);

  localparam int unsigned CW = $clog2(NCH);

  logic [NCH-1:0]        full, empty, push, pop;
  logic [DATA_W-1:0]     fifo_dout [NCH];
  logic [HK_MAX_NCH-1:0] req;
  rr_grant_t             grant;
  logic [CW-1:0]         grant_idx;
  logic                  load;
  logic                  unused_grant_idx;

  logic [CW-1:0]     ptr_q, ptr_d;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [CW-1:0]     rd_ch_q, rd_ch_d;

  // Ready depends only on FIFO state and reset, never on rd_rdy or wr_vld.
  assign wr_rdy = ~full & {NCH{rst_n}};
  assign push   = wr_vld & wr_rdy;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    hk_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push[i]),
      .pop  (pop[i]),
      .din  (wr_data[i*DATA_W +: DATA_W]),
      .dout (fifo_dout[i]),
      .full (full[i]),
      .empty(empty[i])
    );
  end

  assign unused_grant_idx = ^grant.idx;

  // Arbitration: pick the next non-empty channel and pop it when the output register is free.
  always_comb begin
    req            = '0;
    req[NCH-1:0]   = ~empty;
    grant          = rr_next(req, 4'(ptr_q), NCH);
    grant_idx      = grant.idx[CW-1:0];
    load           = grant.vld && (!rd_vld_q || rd_rdy);
    pop            = '0;
    ptr_d          = ptr_q;
    if (load) begin
      pop[grant_idx] = 1'b1;
      ptr_d          = (32'(grant_idx) == NCH - 1) ? '0 : grant_idx + CW'(1);
    end
  end

  // Output register: reload on grant, otherwise drop valid once the beat is taken.
  always_comb begin
    rd_vld_d  = rd_vld_q;
    rd_data_d = rd_data_q;
    rd_ch_d   = rd_ch_q;
    if (load) begin
      rd_vld_d  = 1'b1;
      rd_data_d = fifo_dout[grant_idx];
      rd_ch_d   = grant_idx;
    end else if (rd_rdy) begin
      rd_vld_d  = 1'b0;
    end
  end

  // State update; reset discards the pending output beat and restarts arbitration at ch0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      rd_ch_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
      rd_ch_q   <= rd_ch_d;
    end
  end

  assign rd_vld  = rd_vld_q;
  assign rd_data = rd_data_q;
  assign rd_ch   = rd_ch_q;

endmodule

// File: tb/tb_hk_rr_mux.sv
// Scoreboard bench for hk_rr_mux: queue-based model predicts every output beat.
module tb_hk_rr_mux;

  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    wr_vld;
  logic [NCH-1:0]    wr_rdy;
  logic [NCH*DW-1:0] wr_data;
  logic              rd_vld;
  logic              rd_rdy;
  logic [DW-1:0]     rd_data;
  logic [CW-1:0]     rd_ch;

  hk_rr_mux #(
    .NCH   (NCH),
    .DATA_W(DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (wr_vld),
    .wr_rdy (wr_rdy),
    .wr_data(wr_data),
    .rd_vld (rd_vld),
    .rd_rdy (rd_rdy),
    .rd_data(rd_data),
    .rd_ch  (rd_ch)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; logic [DW-1:0] data; } beat_t;
  typedef struct { int cyc; int ch; logic [DW-1:0] data; } seen_t;

  logic [DW-1:0] src [NCH][$];  // beats each source still has to send
  logic [DW-1:0] fq  [NCH][$];  // model: beats waiting in each channel buffer
  beat_t         sb  [$];       // expected beats, in the order the output should present them
  seen_t         seen[$];       // beats actually handed off on the read side
  int            m_ptr = 0;
  bit            m_vld = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int vld_pct, rdy_pct;

  bit                chk_en = 1'b0;
  bit                p_rst  = 1'b1;
  bit                p_vld  = 1'b0;
  bit                p_rdy  = 1'b0;
  logic [DW-1:0]     p_data = '0;
  logic [CW-1:0]     p_ch   = '0;
  logic [NCH-1:0]    p_wv   = '0;
  logic [NCH-1:0]    p_wr   = '0;
  logic [NCH*DW-1:0] p_wd   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit idle();
    bit r = (wr_vld == '0) && !m_vld;
    for (int i = 0; i < NCH; i++) r = r && (src[i].size() == 0) && (fq[i].size() == 0);
    return r;
  endfunction

  // Monitor and reference model, evaluated on the falling edge while inputs are stable.
  always @(negedge clk) begin : monitor
    logic [NCH-1:0] exp_rdy, acc_m;
    int             g, c;
    beat_t          b;
    bit             new_beat;
    cyc++;
    for (int i = 0; i < NCH; i++) exp_rdy[i] = rst_n && (fq[i].size() < DEPTH);
    if (chk_en) begin
      check("wr_rdy", 32'(wr_rdy), 32'(exp_rdy));
      check("rd_vld", 32'(rd_vld), 32'(m_vld));
      if (!p_rst) begin
        check("reset_rd_data", 32'(rd_data), 32'h0);
        check("reset_rd_ch", 32'(rd_ch), 32'h0);
      end
      if (rd_vld === 1'b1) begin
        new_beat = !p_rst || !p_vld || p_rdy;
        if (new_beat) begin
          if (sb.size() == 0) begin
            check("expected_beat_available", 32'(sb.size()), 32'h1);
          end else begin
            b = sb.pop_front();
            check("rd_ch", 32'(rd_ch), 32'(b.ch));
            check("rd_data", 32'(rd_data), 32'(b.data));
          end
        end else begin
          check("hold_rd_data", 32'(rd_data), 32'(p_data));
          check("hold_rd_ch", 32'(rd_ch), 32'(p_ch));
        end
        if (rd_rdy) seen.push_back('{cyc, int'(rd_ch), rd_data});
      end
      // Source protocol: a pending beat stays valid with unchanged data.
      for (int i = 0; i < NCH; i++) begin
        if (p_rst && rst_n && p_wv[i] && !p_wr[i]) begin
          check("src_hold", 32'({wr_vld[i], wr_data[i*DW +: DW]}),
                32'({1'b1, p_wd[i*DW +: DW]}));
        end
      end
    end

    // Advance the model across the coming rising edge.
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) fq[i].delete();
      sb.delete();
      m_vld = 1'b0;
      m_ptr = 0;
    end else begin
      for (int i = 0; i < NCH; i++) acc_m[i] = wr_vld[i] && (fq[i].size() < DEPTH);
      if (!m_vld || rd_rdy) begin
        g = -1;
        for (int k = 0; k < NCH; k++) begin
          c = (m_ptr + k) % NCH;
          if (g < 0 && fq[c].size() > 0) g = c;
        end
        if (g >= 0) begin
          sb.push_back('{g, fq[g].pop_front()});
          m_vld = 1'b1;
          m_ptr = (g + 1) % NCH;
        end else begin
          m_vld = 1'b0;
        end
      end
      for (int i = 0; i < NCH; i++) if (acc_m[i]) fq[i].push_back(wr_data[i*DW +: DW]);
    end

    p_rst  = rst_n;
    p_vld  = (rd_vld === 1'b1);
    p_rdy  = rd_rdy;
    p_data = rd_data;
    p_ch   = rd_ch;
    p_wv   = wr_vld;
    p_wr   = wr_rdy;
    p_wd   = wr_data;
    chk_en = chk_en || !rst_n;
  end

  // One clock of stimulus: retire accepted beats, offer new ones, randomise rd_rdy.
  task automatic tick();
    logic [NCH-1:0] acc;
    @(negedge clk);
    acc = wr_vld & wr_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (acc[i]) begin
        void'(src[i].pop_front());
        wr_vld[i] = 1'b0;
      end
      if (!wr_vld[i] && src[i].size() != 0 && $urandom_range(99) < vld_pct) begin
        wr_vld[i]              = 1'b1;
        wr_data[i*DW +: DW]    = src[i][0];
      end
    end
    rd_rdy = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (!idle() && n < limit) begin
      tick();
      n++;
    end
    check("drain_done", 32'(idle()), 32'h1);
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_vld  = '0;
    wr_data = '0;
    rd_rdy  = 1'b0;
    vld_pct = 100;
    rdy_pct = 100;

    // Reset with every channel requesting; nothing may be accepted until release.
    for (int i = 0; i < NCH; i++) src[i].push_back(8'(8'hE0 + i));
    repeat (4) tick();
    check("reset_wr_vld_held", 32'(wr_vld), 32'hF);
    rst_n = 1'b1;
    seen.delete();
    drain(100);
    check("reset_beats", 32'(seen.size()), 32'd4);
    for (int k = 0; k < seen.size() && k < 4; k++) check("reset_order", 32'(seen[k].ch), 32'(k));

    // Full load: every channel streaming, output always ready.
    seen.delete();
    for (int i = 0; i < NCH; i++) for (int k = 0; k < 4; k++) src[i].push_back(8'(i * 16 + k));
    drain(200);
    check("full_beats", 32'(seen.size()), 32'd16);
    for (int k = 0; k < seen.size() && k < 16; k++) begin
      check("full_rr_ch", 32'(seen[k].ch), 32'(k % 4));
      check("full_data", 32'(seen[k].data), 32'((k % 4) * 16 + k / 4));
    end
    if (seen.size() == 16) check("full_rate", 32'(seen[15].cyc - seen[0].cyc), 32'd15);

    // Single beat on ch2.
    seen.delete();
    src[2].push_back(8'hA5);
    drain(50);
    check("single_beats", 32'(seen.size()), 32'd1);
    if (seen.size() > 0) begin
      check("single_ch", 32'(seen[0].ch), 32'd2);
      check("single_data", 32'(seen[0].data), 32'hA5);
    end

    // Backpressure: FIFO plus output register absorb three beats.
    rdy_pct = 0;
    src[0].push_back(8'h11);
    src[0].push_back(8'h22);
    src[0].push_back(8'h33);
    repeat (6) tick();
    check("bp_all_taken", 32'(src[0].size()), 32'd0);
    check("bp_wr_rdy0", 32'(wr_rdy[0]), 32'd0);
    check("bp_rd_vld", 32'(rd_vld), 32'd1);
    check("bp_rd_data", 32'(rd_data), 32'h11);
    rdy_pct = 100;
    seen.delete();
    drain(50);
    check("bp_beats", 32'(seen.size()), 32'd3);
    for (int k = 0; k < seen.size() && k < 3; k++) begin
      check("bp_order", 32'(seen[k].data), 32'(8'h11 * (k + 1)));
    end

    // Sparse fairness: only ch1 and ch3 busy.
    seen.delete();
    for (int k = 0; k < 8; k++) begin
      src[1].push_back(8'(8'h40 + k));
      src[3].push_back(8'(8'h60 + k));
    end
    drain(100);
    check("sparse_beats", 32'(seen.size()), 32'd16);
    for (int k = 0; k < seen.size(); k++) check("sparse_alt", 32'(seen[k].ch), (k % 2) ? 32'd3 : 32'd1);

    // Mid-stream reset with five beats buffered.
    rdy_pct = 0;
    src[1].push_back(8'h91);
    src[1].push_back(8'h92);
    src[2].push_back(8'hA1);
    src[2].push_back(8'hA2);
    src[3].push_back(8'hB1);
    repeat (6) tick();
    check("mid_buffered", 32'(src[1].size() + src[2].size() + src[3].size()), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen.delete();
    rdy_pct = 100;
    for (int i = 0; i < NCH; i++) src[i].push_back(8'(8'hC0 + i));
    drain(100);
    check("mid_beats", 32'(seen.size()), 32'd4);
    for (int k = 0; k < seen.size() && k < 4; k++) begin
      check("mid_rr_restart", 32'(seen[k].ch), 32'(k));
      check("mid_data", 32'(seen[k].data), 32'(8'hC0 + k));
    end

    // Randomised traffic under varied offer and drain rates.
    for (int ph = 0; ph < 3; ph++) begin
      vld_pct = (ph == 0) ? 70 : (ph == 1) ? 30 : 100;
      rdy_pct = (ph == 0) ? 60 : (ph == 1) ? 90 : 30;
      seen.delete();
      for (int i = 0; i < NCH; i++) for (int k = 0; k < 20; k++) src[i].push_back(8'($urandom_range(255)));
      drain(3000);
      check("rand_beats", 32'(seen.size()), 32'd80);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
